// File: rtl/bit_ops_seq.sv
// bit_ops_seq: multi-cycle rotate/shift/bit unit (RLC/RRC/RL/RR/SLA/SRA/SWAP/SRL
// repeated COUNT times, or BIT/RES/SET on a selected bit).
//
// Build option: BIT_OPS_SEQ_BARREL_EN
//    undefined : iterative engine, one shift step per RUN cycle
//    defined   : the whole repeat count is applied in a single RUN cycle
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; outputs hold the last result
// S_RUN  | working value/carry being stepped (or bit op being evaluated)
// S_DONE | result registers valid, done pulse; a new start is accepted here
module bit_ops_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4,
   parameter int SEL_W = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [SEL_W-1:0] bit_sel,
   input  logic [CNT_W-1:0] count,
   input  logic [WIDTH-1:0] data_in,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] data_out,
   output logic             c_out,
   output logic             z_out,
   output logic             h_out
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int MAX_CNT = (1 << CNT_W) - 1;

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             last_step;

   logic [4:0]       op_q;
   logic [SEL_W-1:0] sel_q;
   logic [CNT_W-1:0] remaining;
   logic [WIDTH-1:0] work;
   logic             carry_w;

   logic             is_shift;
   logic [WIDTH-1:0] mask;
   logic [WIDTH:0]   shift_val;
   logic [WIDTH-1:0] res_data;
   logic             res_c;
   logic             res_z;
   logic             res_h;

   // One single-bit step of the selected shift; returns {carry, value}.
   function automatic logic [WIDTH:0] shift_step(
      input logic [2:0]       sop,
      input logic [WIDTH-1:0] w,
      input logic             c
   );
      logic [WIDTH-1:0] nw;
      logic             nc;
      nw = w;
      nc = c;
      case (sop)
         3'd0: begin nw = {w[WIDTH-2:0], w[WIDTH-1]}; nc = w[WIDTH-1]; end
         3'd1: begin nw = {w[0], w[WIDTH-1:1]};       nc = w[0];       end
         3'd2: begin nw = {w[WIDTH-2:0], c};          nc = w[WIDTH-1]; end
         3'd3: begin nw = {c, w[WIDTH-1:1]};          nc = w[0];       end
         3'd4: begin nw = {w[WIDTH-2:0], 1'b0};       nc = w[WIDTH-1]; end
         3'd5: begin nw = {w[WIDTH-1], w[WIDTH-1:1]}; nc = w[0];       end
         3'd6: begin nw = {w[WIDTH/2-1:0], w[WIDTH-1:WIDTH/2]}; nc = 1'b0; end
         default: begin nw = {1'b0, w[WIDTH-1:1]};    nc = w[0];       end
      endcase
      return {nc, nw};
   endfunction

`ifdef BIT_OPS_SEQ_BARREL_EN
   // Chained copies of the single step so results match the iterative engine exactly.
   function automatic logic [WIDTH:0] shift_multi(
      input logic [2:0]       sop,
      input logic [WIDTH-1:0] w,
      input logic             c,
      input logic [CNT_W-1:0] n
   );
      logic [WIDTH:0] acc;
      acc = {c, w};
      for (int i = 0; i < MAX_CNT; i++) begin
         if (i < int'(n)) begin
            acc = shift_step(sop, acc[WIDTH-1:0], acc[WIDTH]);
         end
      end
      return acc;
   endfunction
`endif

   assign is_shift = (op_q[4:3] == 2'b00);

`ifdef BIT_OPS_SEQ_BARREL_EN
   assign last_step = 1'b1;
`else
   assign last_step = !is_shift || (remaining <= CNT_W'(1));
`endif

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode, acceptance and status outputs.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      case (state)
         S_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (last_step) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // One-hot mask of the selected bit; an out-of-range index selects nothing.
   always_comb begin
      mask = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (sel_q == SEL_W'(i)) begin
            mask[i] = 1'b1;
         end
      end
   end

   // Final result and flags as they will be registered on the last RUN cycle.
   always_comb begin
`ifdef BIT_OPS_SEQ_BARREL_EN
      shift_val = shift_multi(op_q[2:0], work, carry_w, remaining);
`else
      shift_val = (remaining == '0) ? {carry_w, work} : shift_step(op_q[2:0], work, carry_w);
`endif
      res_data = work;
      res_c    = carry_w;
      res_z    = 1'b0;
      res_h    = 1'b0;
      case (op_q[4:3])
         2'd0: begin
            res_data = shift_val[WIDTH-1:0];
            res_c    = shift_val[WIDTH];
            res_z    = (shift_val[WIDTH-1:0] == '0);
         end
         2'd1: begin
            res_z = ~|(work & mask);
            res_h = 1'b1;
         end
         2'd2: begin
            res_data = work & ~mask;
            res_z    = ((work & ~mask) == '0);
         end
         default: begin
            res_data = work | mask;
            res_z    = ((work | mask) == '0);
         end
      endcase
   end

   // Operand capture, iterative stepping and result registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         op_q      <= '0;
         sel_q     <= '0;
         remaining <= '0;
         work      <= '0;
         carry_w   <= 1'b0;
         data_out  <= '0;
         c_out     <= 1'b0;
         z_out     <= 1'b0;
         h_out     <= 1'b0;
      end else begin
         if (accept) begin
            op_q      <= op;
            sel_q     <= bit_sel;
            remaining <= count;
            work      <= data_in;
            carry_w   <= c_in;
         end else if (state == S_RUN) begin
`ifndef BIT_OPS_SEQ_BARREL_EN
            if (is_shift && !last_step) begin
               {carry_w, work} <= shift_step(op_q[2:0], work, carry_w);
               remaining       <= remaining - CNT_W'(1);
            end
`endif
            if (last_step) begin
               data_out <= res_data;
               c_out    <= res_c;
               z_out    <= res_z;
               h_out    <= res_h;
            end
         end
      end
   end

endmodule
